// File: rtl/nibble_seq_pkg.sv
// nibble_seq_pkg: shared state encoding, default sizing and derived widths for nibble_seq_ctrl
package nibble_seq_pkg;
    typedef enum logic {LOAD = 1'b0, PLAY = 1'b1} state_t;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_STEP_CYCLES = 4;
    localparam int PTR_W = $clog2(DEF_DEPTH);
    localparam int CNT_W = $clog2(DEF_DEPTH + 1);
    localparam int TICK_W = $clog2(DEF_STEP_CYCLES);
endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchronizer followed by a one-cycle rising-edge pulse
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);
    logic s1, s2, s3;
    always_ff @(posedge clk) begin
        if (!reset) {s1, s2, s3} <= 3'b000;
        else {s1, s2, s3} <= {sig, s1, s2};
    end
    assign rise = s2 & ~s3;
endmodule

// File: rtl/nibble_seq_ctrl.sv
// nibble_seq_ctrl: assembles strobed nibbles into a byte program and plays it back at a fixed step rate
module nibble_seq_ctrl
    import nibble_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic       valid,
    input  logic       toggle,
    output logic [7:0] dout,
    output logic       mode,
    output logic       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(STEP_CYCLES);
    state_t state;
    logic phase, paused, val_ev, tog_ev, we;
    logic [3:0] lo_nib;
    logic [7:0] last;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] tick;
    logic [7:0] mem [DEPTH];
    edge_sync u_valid (.clk(clk), .reset(reset), .sig(valid), .rise(val_ev));
    edge_sync u_toggle (.clk(clk), .reset(reset), .sig(toggle), .rise(tog_ev));
    assign full = count == CW'(DEPTH);
    assign mode = state == PLAY;
    assign dout = (state == PLAY) ? mem[rd_ptr] : last;
    assign we = state == LOAD && !tog_ev && val_ev && phase && !full;
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= {din, lo_nib};
    end
    // a toggle event always wins; a coincident valid event is simply ignored
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LOAD;
            phase <= 1'b0;
            lo_nib <= 4'h0;
            last <= 8'h00;
            wr_ptr <= '0;
            count <= '0;
            rd_ptr <= '0;
            tick <= '0;
            paused <= 1'b0;
        end else if (tog_ev) begin
            phase <= 1'b0;
            if (state == PLAY) begin
                state <= LOAD;
                count <= '0;
                wr_ptr <= '0;
                last <= 8'h00;
            end else if (count != '0) begin
                state <= PLAY;
                rd_ptr <= '0;
                tick <= '0;
                paused <= 1'b0;
            end
        end else if (state == LOAD) begin
            if (val_ev && !phase) begin
                lo_nib <= din;
                phase <= 1'b1;
            end else if (val_ev) begin
                phase <= 1'b0;
                if (!full) begin
                    last <= {din, lo_nib};
                    wr_ptr <= wr_ptr + PW'(1);
                    count <= count + CW'(1);
                end
            end
        end else begin
            if (val_ev) paused <= ~paused;
            if (!paused) begin
                tick <= (tick == TW'(STEP_CYCLES - 1)) ? '0 : tick + TW'(1);
                if (tick == TW'(STEP_CYCLES - 1))
                    rd_ptr <= (CW'(rd_ptr) == count - CW'(1)) ? '0 : rd_ptr + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_nibble_seq_ctrl.sv
// tb_nibble_seq_ctrl: directed checks of load, playback, overflow, pause, priority and reset behaviour
module tb_nibble_seq_ctrl;
    logic clk = 1'b0;
    logic reset, valid, toggle;
    logic [3:0] din;
    logic [7:0] dout;
    logic mode, full;
    int checks = 0;
    int errors = 0;
    nibble_seq_ctrl #(.DEPTH(8), .STEP_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .din(din), .valid(valid), .toggle(toggle),
        .dout(dout), .mode(mode), .full(full)
    );
    always #5 clk = ~clk;
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic nib(input logic [3:0] v);
        din = v;
        valid = 1'b1;
        step(4);
        valid = 1'b0;
        step(4);
    endtask
    task automatic put_byte(input logic [7:0] b);
        nib(b[3:0]);
        nib(b[7:4]);
    endtask
    task automatic tog_pulse();
        toggle = 1'b1;
        step(4);
        toggle = 1'b0;
        step(4);
    endtask
    initial begin
        reset = 1'b0;
        valid = 1'b0;
        toggle = 1'b0;
        din = 4'($urandom);
        step(2);
        chk("rst_dout", dout, 8'h00);
        chk("rst_mode", {7'd0, mode}, 8'h00);
        chk("rst_full", {7'd0, full}, 8'h00);
        reset = 1'b1;
        step(4);
        put_byte(8'hA5);
        chk("load_a5", dout, 8'hA5);
        put_byte(8'hC3);
        chk("load_c3", dout, 8'hC3);
        chk("load_mode", {7'd0, mode}, 8'h00);
        toggle = 1'b1;
        step(3);
        chk("play_mode", {7'd0, mode}, 8'h01);
        toggle = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("play_seq", dout, ((i / 4) % 2) ? 8'hC3 : 8'hA5);
            step(1);
        end
        toggle = 1'b1;
        step(3);
        chk("exit_mode", {7'd0, mode}, 8'h00);
        chk("exit_dout", dout, 8'h00);
        toggle = 1'b0;
        step(4);
        for (int b = 1; b <= 9; b++) begin
            put_byte(8'(b));
            chk("ovf_full", {7'd0, full}, (b >= 8) ? 8'h01 : 8'h00);
            chk("ovf_last", dout, (b >= 8) ? 8'h08 : 8'(b));
        end
        toggle = 1'b1;
        step(3);
        toggle = 1'b0;
        for (int i = 0; i < 36; i++) begin
            chk("ovf_play", dout, 8'(((i / 4) % 8) + 1));
            step(1);
        end
        toggle = 1'b1;
        step(3);
        chk("ovf_exit", {7'd0, mode}, 8'h00);
        chk("ovf_clr", {7'd0, full}, 8'h00);
        toggle = 1'b0;
        step(4);
        toggle = 1'b1;
        step(3);
        chk("empty_tog", {7'd0, mode}, 8'h00);
        toggle = 1'b0;
        step(4);
        nib(4'h7);
        tog_pulse();
        chk("half_tog", {7'd0, mode}, 8'h00);
        put_byte(8'h21);
        chk("half_drop", dout, 8'h21);
        toggle = 1'b1;
        step(3);
        toggle = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("single_play", dout, 8'h21);
            step(1);
        end
        tog_pulse();
        put_byte(8'hA5);
        put_byte(8'hC3);
        toggle = 1'b1;
        step(3);
        toggle = 1'b0;
        valid = 1'b1;
        step(3);
        valid = 1'b0;
        chk("pause_start", dout, 8'hA5);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("pause_hold", dout, 8'hA5);
        end
        valid = 1'b1;
        step(3);
        valid = 1'b0;
        chk("resume_edge", dout, 8'hA5);
        step(1);
        chk("resume_step", dout, 8'hC3);
        step(3);
        chk("resume_c3", dout, 8'hC3);
        step(1);
        chk("resume_wrap", dout, 8'hA5);
        valid = 1'b1;
        toggle = 1'b1;
        step(3);
        chk("sim_mode", {7'd0, mode}, 8'h00);
        chk("sim_dout", dout, 8'h00);
        chk("sim_full", {7'd0, full}, 8'h00);
        valid = 1'b0;
        toggle = 1'b0;
        step(4);
        put_byte(8'hA5);
        chk("sim_nodrop", dout, 8'hA5);
        put_byte(8'hC3);
        toggle = 1'b1;
        step(3);
        toggle = 1'b0;
        step(4);
        chk("mid_rd1", dout, 8'hC3);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk("mid_mode", {7'd0, mode}, 8'h00);
        chk("mid_dout", dout, 8'h00);
        chk("mid_full", {7'd0, full}, 8'h00);
        toggle = 1'b1;
        step(3);
        chk("mid_tog", {7'd0, mode}, 8'h00);
        toggle = 1'b0;
        step(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_seq_ctrl.md
Name: nibble_seq_ctrl

Overview:
Control block for the 4-bit-in / 8-bit-out pin datapath. It assembles pairs of nibbles strobed on din/valid into bytes and stores them in a small program buffer. On toggle it switches to playback, which steps through the stored bytes on dout at a fixed tick rate. It sits directly behind the top-level io_in/io_out pins; the top wrapper maps io_in = {toggle, valid, reset, clk, din} and io_out = dout.

Parameters:
DEPTH, 8, number of byte entries in the program buffer (power of 2, 2..16)
STEP_CYCLES, 4, clk cycles per playback step (>=2; small default for simulation)

Ports:
clk     input   1  system clock, the only clock
reset   input   1  synchronous, active-low reset (0 = reset), sampled on rising clk
din     input   4  nibble data from pins, asynchronous, held stable while valid is high
valid   input   1  asynchronous nibble strobe; a rising edge is one event
toggle  input   1  asynchronous mode strobe; a rising edge is one event
dout    output  8  LOAD: last completed byte; PLAY: mem[rd_ptr]
mode    output  1  0 = LOAD, 1 = PLAY
full    output  1  count == DEPTH

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = LOAD; phase = 0; lo_nib = 0; last = 0x00; wr_ptr = 0; count = 0; rd_ptr = 0; tick = 0; paused = 0; synchronizer flops = 0.
  - Outputs after reset: dout = 0x00, mode = 0, full = 0.
  - Buffer contents are not reset.
  - Reset mid-operation discards any pending nibble and the whole program.
- Input conditioning:
  - valid and toggle each pass through a 2-flop synchronizer and a rising-edge detector (s2 & ~s3).
  - Latency: an input rising between edges k-1 and k is acted on at edge k+2 (3rd edge). din is sampled at that same edge.
  - Pulses shorter than one clk period may be lost; this is accepted.
- Priority: toggle event beats valid event in the same cycle. The valid event is dropped.
- LOAD state:
  - Valid event with phase = 0: lo_nib <= din, phase <= 1.
  - Valid event with phase = 1 and count < DEPTH:
    - mem[wr_ptr] <= {din, lo_nib}; last <= {din, lo_nib};
    - wr_ptr++ (wraps mod DEPTH); count++; phase <= 0.
  - Valid event with phase = 1 and count == DEPTH: byte is dropped (mem, last and count unchanged); phase <= 0.
  - Toggle event with count > 0: state <= PLAY; rd_ptr <= 0; tick <= 0; paused <= 0; phase <= 0 (half nibble discarded).
  - Toggle event with count == 0: no state change; phase <= 0.
- PLAY state:
  - dout = mem[rd_ptr] (combinational mux from registers).
  - When not paused, tick counts 0..STEP_CYCLES-1. On tick == STEP_CYCLES-1: tick <= 0, and rd_ptr <= (rd_ptr == count-1) ? 0 : rd_ptr+1.
  - Each byte is therefore shown exactly STEP_CYCLES cycles; count == 1 shows mem[0] constantly.
  - Valid event: paused <= ~paused. While paused, tick and rd_ptr hold; on resume counting continues from the held tick.
  - Toggle event: state <= LOAD; count <= 0; wr_ptr <= 0; last <= 0x00; phase <= 0. This clears the program for reload.
- Widths:
  - count is clog2(DEPTH+1) bits.
  - wr_ptr and rd_ptr are clog2(DEPTH) bits.
  - tick is clog2(STEP_CYCLES) bits.
  - No counter may overflow past the bounds stated above.

Decomposition:
- Shared package nibble_seq_pkg:
  - state enum (LOAD = 1'b0, PLAY = 1'b1);
  - default DEPTH and STEP_CYCLES constants;
  - pointer and count width localparams derived via $clog2.
- One sub-module edge_sync: 2-flop synchronizer plus rising-edge pulse, with the same clk and active-low synchronous reset. Instantiated twice, once for valid and once for toggle.
- Buffer is a flop array inside nibble_seq_ctrl (no RAM macro).

Test Plan:
- Reset: hold reset = 0 for 2 cycles with random pins -> dout = 0x00, mode = 0, full = 0; no event acted on until 3 edges after release.
- Load and play: strobe nibbles 0x5, 0xA, 0x3, 0xC (each held 4 cycles, gaps of 4), then toggle -> dout = 0xA5 then 0xC3 in LOAD; PLAY shows 0xA5 for 4 cycles, 0xC3 for 4 cycles, then 0xA5 again (wrap).
- Overflow: load 9 bytes 0x01..0x09 with DEPTH = 8 -> full = 1 after the 8th byte; last stays 0x08; playback cycles 0x01..0x08 only.
- Empty toggle and half nibble: toggle with count = 0 -> mode stays 0. Then one nibble 0x7 followed by toggle, then bytes 0x21 -> stored byte is 0x21; the stray 0x7 is discarded.
- Pause and simultaneous: in PLAY, a valid edge freezes dout for 20 cycles and a second valid edge resumes with the remaining tick count. Valid and toggle rising in the same cycle -> mode = 0, count = 0, no pause toggle.
- Reset mid-play: assert reset during PLAY at rd_ptr = 1 -> next cycle mode = 0, dout = 0x00, count = 0; a subsequent toggle alone does not enter PLAY.
